// File: rtl/des_pkg.sv
// Shared DES constants: FSM states, rotation schedule, permutation tables, S-boxes.
// Bit vectors use DES numbering [1:N], bit 1 = MSB; tables hold 1-based source indices.
package des_pkg;
    localparam int BLK_W  = 64;
    localparam int KEY_W  = 56;
    localparam int SUB_W  = 48;
    localparam int HALF_W = 32;
    localparam int CD_W   = 28;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Encrypt left-rotate amount for rounds 1..16.
    localparam logic [0:15][1:0] SHIFTS = {2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                           2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                 62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                 57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                 61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                 38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                 36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                 34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                  10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                  63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                  14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                  23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                  41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                  44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    // S[n] entry at (row*16 + col), first nibble in each literal is entry 0.
    localparam logic [0:7][0:63][3:0] SBOX = {
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic logic [1:64] perm_ip(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[IP_T[i]];
        return y;
    endfunction

    function automatic logic [1:64] perm_fp(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[FP_T[i]];
        return y;
    endfunction

    function automatic logic [1:56] perm_pc1(input logic [1:64] x);
        logic [1:56] y;
        for (int i = 0; i < 56; i++) y[i+1] = x[PC1_T[i]];
        return y;
    endfunction

    function automatic logic [1:48] perm_pc2(input logic [1:56] x);
        logic [1:48] y;
        for (int i = 0; i < 48; i++) y[i+1] = x[PC2_T[i]];
        return y;
    endfunction

    function automatic logic [1:32] perm_p(input logic [1:32] x);
        logic [1:32] y;
        for (int i = 0; i < 32; i++) y[i+1] = x[P_T[i]];
        return y;
    endfunction

    function automatic logic [1:28] rotl28(input logic [1:28] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[2:28], x[1]};
            2'd2:    return {x[3:28], x[1:2]};
            default: return x;
        endcase
    endfunction

    function automatic logic [1:28] rotr28(input logic [1:28] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[28], x[1:27]};
            2'd2:    return {x[27:28], x[1:26]};
            default: return x;
        endcase
    endfunction
endpackage

// File: rtl/des_round_ctrl_if.sv
// Host-side request/response bundle for the iterative DES engine.
interface des_round_ctrl_if;
    logic        in_valid, in_ready, decrypt;
    logic        out_valid, out_ready, busy;
    logic [1:64] in_data, in_key, out_data;

    modport master (output in_valid, in_data, in_key, decrypt, out_ready,
                    input  in_ready, out_valid, out_data, busy);
    modport slave  (input  in_valid, in_data, in_key, decrypt, out_ready,
                    output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/des_f_function.sv
// Combinational Feistel function f(R, K) = P(S(E(R) ^ K)).
module des_f_function
    import des_pkg::*;
(
    input  logic [1:32] r,
    input  logic [1:48] k,
    output logic [1:32] f
);
    logic [1:48] e, x;
    logic [1:32] s;

    selection_table u_e (.r(r), .e(e));

    assign x = e ^ k;

    // Outer bits pick the row, inner four bits the column.
    for (genvar j = 0; j < 8; j++) begin : g_sbox
        logic [5:0] b;
        assign b            = x[6*j+1 +: 6];
        assign s[4*j+1 +: 4] = SBOX[j][{b[5], b[0], b[4:1]}];
    end

    assign f = perm_p(s);
endmodule

// File: rtl/selection_table.sv
// DES expansion E: 32-bit half-block to 48 bits.
module selection_table (
    input  logic [1:32] r,
    output logic [1:48] e
);
    localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
                                8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                                16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                                24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    for (genvar i = 0; i < 48; i++) begin : g_e
        assign e[i+1] = r[E_T[i]];
    end
endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES engine: one Feistel round per clock, 16 rounds per block.
// DES_DECRYPT_EN adds the decrypt mode (right-rotate key schedule); otherwise encrypt-only.
module des_round_ctrl
    import des_pkg::*;
(
    input  logic clk,
    input  logic rst,
    des_round_ctrl_if.slave bus
);
    state_t      state, state_n;
    logic [3:0]  rnd;
    logic [1:32] l, r, f;
    logic [1:28] c, d, c_n, d_n;
    logic [1:48] k;
    logic [1:64] lr0, res, out_q;
    logic [1:56] cd0;
    logic        accept;

    assign accept = (state == IDLE) && bus.in_valid;
    assign lr0    = perm_ip(bus.in_data);
    assign cd0    = perm_pc1(bus.in_key);

`ifdef DES_DECRYPT_EN
    logic       mode;
    logic [1:0] amt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         mode <= 1'b0;
        else if (accept) mode <= bus.decrypt;
    end
`endif

    // Decrypt walks the schedule backwards: round 1 reuses C0D0 (= K16's halves),
    // round n undoes the encrypt shift of round 18-n.
    always_comb begin
        c_n = rotl28(c, SHIFTS[rnd]);
        d_n = rotl28(d, SHIFTS[rnd]);
`ifdef DES_DECRYPT_EN
        amt = (rnd == 4'd0) ? 2'd0 : SHIFTS[4'd0 - rnd];
        if (mode) begin
            c_n = rotr28(c, amt);
            d_n = rotr28(d, amt);
        end
`endif
    end

    assign k = perm_pc2({c_n, d_n});

    des_f_function u_f (.r(r), .k(k), .f(f));

    // Output swap folded in: preoutput is {R16, L16}.
    assign res = perm_fp({l ^ f, r});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_n = ROUND;
            ROUND:   if (rnd == 4'd15)  state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default:                    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l     <= '0;
            r     <= '0;
            c     <= '0;
            d     <= '0;
            rnd   <= '0;
            out_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    l   <= lr0[1:32];
                    r   <= lr0[33:64];
                    c   <= cd0[1:28];
                    d   <= cd0[29:56];
                    rnd <= 4'd0;
                end
                ROUND: begin
                    l   <= r;
                    r   <= l ^ f;
                    c   <= c_n;
                    d   <= d_n;
                    rnd <= rnd + 4'd1;
                    if (rnd == 4'd15) out_q <= res;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == ROUND) || (state == DONE);
    assign bus.out_data  = out_q;
endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: known-answer vectors plus random blocks against a textbook DES model.
module tb_des_round_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef DES_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1, D1 = 64'h0123456789ABCDEF, C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K3 = 64'h0E329232EA6D0D73, D3 = 64'h8787878787878787;

    des_round_ctrl_if bus ();
    des_round_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // ---------------- reference model: standard DES, 0-based [63:0] with DES bit 1 = bit 63
    int IP_Q[$]  = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                     62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                     57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                     61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    int FP_Q[$]  = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                     38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                     36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                     34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    int PC1_Q[$] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                     10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                     14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    int PC2_Q[$] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
                     26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
                     51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int P_Q[$]   = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    int SH[16]   = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    // Output bit i (1-based, MSB first) takes input bit t[i] of an inw-bit value.
    function automatic logic [63:0] perm(input logic [63:0] x, input int inw, input int t[$]);
        logic [63:0] y = '0;
        for (int i = 0; i < t.size(); i++) y[t.size()-1-i] = x[inw - t[i]];
        return y;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] v, input int n);
        return (v << n) | (v >> (28 - n));
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] rr, input logic [47:0] kk);
        logic [47:0] e, x;
        logic [31:0] s;
        logic [5:0]  six;
        logic [63:0] tmp;
        int          src, idx;
        for (int i = 0; i < 48; i++) begin
            src      = ((4 * (i / 6) + i % 6 + 31) % 32) + 1;
            e[47-i]  = rr[32-src];
        end
        x = e ^ kk;
        for (int j = 0; j < 8; j++) begin
            six = x[47-6*j -: 6];
            idx = {six[5], six[0]} * 16 + six[4:1];
            s[31-4*j -: 4] = SB[j][255-4*idx -: 4];
        end
        tmp = perm({32'h0, s}, 32, P_Q);
        return tmp[31:0];
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] data, input logic dec);
        logic [47:0] ks [16];
        logic [63:0] tmp;
        logic [27:0] c, d;
        logic [31:0] l, r, t;
        tmp = perm(key, 64, PC1_Q);
        c = tmp[55:28];
        d = tmp[27:0];
        for (int i = 0; i < 16; i++) begin
            c     = rol28(c, SH[i]);
            d     = rol28(d, SH[i]);
            tmp   = perm({8'h0, c, d}, 56, PC2_Q);
            ks[i] = tmp[47:0];
        end
        tmp = perm(data, 64, IP_Q);
        l = tmp[63:32];
        r = tmp[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ feistel(r, dec ? ks[15-i] : ks[i]);
            l = t;
        end
        return perm({r, l}, 64, FP_Q);
    endfunction

    // ---------------- checking and driving
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [63:0] k, input logic [63:0] dt, input logic dc);
        int b = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_key   = k;
        bus.in_data  = dt;
        bus.decrypt  = dc;
        while (bus.in_ready !== 1'b1 && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (b >= 50) chk("accept timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
        bus.in_key   = {$urandom, $urandom};
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat, acc, gap, outs, bp;
        bit          took;
        logic [63:0] k, dt, kb, db, exp_v;
        logic [63:0] got [2];
        logic        dc;

        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_key = '0;
        bus.decrypt  = 1'b0; bus.out_ready = 1'b0;

        #12;
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset out_data", bus.out_data, 0);
        @(negedge clk) rst = 1'b0;

        // Known answer, round-1 internals, latency and back-pressure
        send(K1, D1, 1'b0);
        @(posedge clk);
        #1;
        chk("busy after accept", bus.busy, 1);
        chk("round1 L", dut.l, 64'hF0AAF0AA);
        chk("round1 R", dut.r, 64'hEF4A6544);
        wait_done(1, lat);
        chk("kat1 latency", lat, 16);
        chk("kat1 data", bus.out_data, C1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                bus.in_valid = 1'b1;
                bus.in_data  = {$urandom, $urandom};
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            chk("bp out_valid", bus.out_valid, 1);
            chk("bp out_data", bus.out_data, C1);
            chk("bp in_ready", bus.in_ready, 0);
        end
        handshake();
        chk("post hs in_ready", bus.in_ready, 1);
        chk("post hs busy", bus.busy, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("bp pulse ignored", bus.out_valid | bus.busy, 0);

        // out_ready already high: handshake in the first DONE cycle
        bus.out_ready = 1'b1;
        send(K3, D3, 1'b0);
        wait_done(0, lat);
        chk("kat3 latency", lat, 16);
        chk("kat3 data", bus.out_data, 64'h0);
        @(posedge clk);
        #1;
        chk("early ready out_valid", bus.out_valid, 0);
        chk("early ready in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;

        // Decrypt request; encrypt-only builds must treat it as encrypt
        send(K1, C1, 1'b1);
        wait_done(0, lat);
        exp_v = DEC_EN ? D1 : des_model(K1, C1, 1'b0);
        chk("decrypt kat", bus.out_data, exp_v);
        handshake();

        // Asynchronous reset mid-block
        send(K1, D1, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        chk("rnd at 7", dut.rnd, 7);
        #2 rst = 1'b1;
        #1;
        chk("mid rst out_valid", bus.out_valid, 0);
        chk("mid rst in_ready", bus.in_ready, 1);
        chk("mid rst busy", bus.busy, 0);
        chk("mid rst out_data", bus.out_data, 0);
        @(negedge clk) rst = 1'b0;
        send(K3, D3, 1'b0);
        wait_done(0, lat);
        chk("after rst latency", lat, 16);
        chk("after rst data", bus.out_data, 64'h0);
        handshake();

        // Back-to-back with in_valid and out_ready held high
        kb = {$urandom, $urandom};
        db = {$urandom, $urandom};
        got[0] = '0; got[1] = '0;
        acc = 0; gap = 0; outs = 0;
        bus.out_ready = 1'b1;
        bus.in_key = K1; bus.in_data = D1; bus.decrypt = 1'b0; bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 80 && outs < 2; cyc++) begin
            @(negedge clk);
            took = (bus.in_ready === 1'b1) && acc < 2;
            if (took) begin
                acc++;
                if (acc == 2) chk("b2b busy cycles between accepts", gap, 17);
            end else if (acc == 1) gap++;
            if (bus.out_valid === 1'b1) begin
                got[outs] = bus.out_data;
                outs++;
            end
            @(posedge clk);
            #1;
            if (took && acc == 1) begin
                bus.in_key  = kb;
                bus.in_data = db;
            end
            if (acc == 2) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b outputs", outs, 2);
        chk("b2b first", got[0], C1);
        chk("b2b second", got[1], des_model(kb, db, 1'b0));

        // Random blocks with random back-pressure
        for (int n = 0; n < 24; n++) begin
            k  = {$urandom, $urandom};
            dt = {$urandom, $urandom};
            dc = 1'($urandom_range(0, 1));
            bp = $urandom_range(0, 3);
            send(k, dt, dc);
            wait_done(0, lat);
            chk("rand latency", lat, 16);
            exp_v = des_model(k, dt, dc & DEC_EN);
            chk("rand data", bus.out_data, exp_v);
            repeat (bp) @(posedge clk);
            #1;
            chk("rand held data", bus.out_data, exp_v);
            handshake();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
